branch_stall_ctrl: RTL and testbench

Pipeline control block that consumes the ID-stage branch hazard unit's per-operand forwarding codes and turns them into pipeline enables, bubbles, flushes and one-cycle write-back forwarding selects. It sits beside the ID stage: the hazard unit reports *what* the branch/jump operand depends on; this block decides *how the pipeline reacts* over the following cycles. It also keeps saturating stall/flush performance counters and a sticky watchdog error.

---
 rtl/branch_stall_ctrl.sv | 71 +++++++
 tb/tb_branch_stall_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/branch_stall_ctrl.sv
// branch_stall_ctrl: turns ID-stage branch hazard codes into pipeline enables,
// bubbles, flushes and one-cycle WB forward selects; keeps stall/flush counters
// and a sticky stall watchdog.
// Ports: clk, rst_n (async active-low); signalA/signalB operand forwarding codes
// (5 = load, needs stall); ex_load_use (load in ID/EX); branch_taken, jump;
// pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_wb_a, fwd_wb_b;
// stall_cnt, flush_cnt (saturating); hazard_err (sticky).
module branch_stall_ctrl #(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       signalA,
   input  logic [2:0]       signalB,
   input  logic             ex_load_use,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             fwd_wb_a,
   output logic             fwd_wb_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             hazard_err
);
   typedef enum logic [1:0] {RUN = 2'd0, EXWAIT = 2'd1, LWAIT = 2'd2} state_t;
   state_t     state, state_nx;
   logic       cap_a, cap_b, ld_a, ld_b, ld, redirect, stall;
   logic [3:0] run_cnt, run_nx;
   always_comb begin
      ld_a         = signalA == 3'd5;
      ld_b         = signalB == 3'd5;
      ld           = ld_a | ld_b;
      redirect     = branch_taken | jump;
      // in LWAIT the load already reached WB, so ex_load_use no longer applies
      stall        = (state == LWAIT) ? ld : (ex_load_use | ld);
      pc_en        = ~stall;
      if_id_en     = ~stall;
      id_ex_bubble = stall;
      if_id_flush  = ~stall & redirect;
      fwd_wb_a     = (state == LWAIT) & cap_a;
      fwd_wb_b     = (state == LWAIT) & cap_b;
      state_nx     = (state != LWAIT && ex_load_use) ? EXWAIT : ld ? LWAIT : RUN;
      run_nx       = stall ? ((run_cnt == 4'hF) ? run_cnt : run_cnt + 4'd1) : 4'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         cap_a      <= 1'b0;
         cap_b      <= 1'b0;
         run_cnt    <= 4'd0;
         hazard_err <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         state   <= state_nx;
         cap_a   <= (state_nx == LWAIT) & ld_a;
         cap_b   <= (state_nx == LWAIT) & ld_b;
         run_cnt <= run_nx;
         if (run_nx >= 4'(MAX_STALL))
            hazard_err <= 1'b1;
         if (id_ex_bubble && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (if_id_flush && !(&flush_cnt))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_branch_stall_ctrl.sv
// tb_branch_stall_ctrl: directed and random stimulus checked against a
// behavioural model of the stall/forward/flush rules; a second instance with
// 2-bit counters exercises counter saturation.
module tb_branch_stall_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [2:0]  signalA = 3'd0, signalB = 3'd0;
   logic        ex_load_use = 1'b0, branch_taken = 1'b0, jump = 1'b0;
   logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_wb_a, fwd_wb_b, hazard_err;
   logic [15:0] stall_cnt, flush_cnt;
   logic        pc_en2, if_id_en2, if_id_flush2, id_ex_bubble2, fwd_wb_a2, fwd_wb_b2, hazard_err2;
   logic [1:0]  stall_cnt2, flush_cnt2;
   int compared = 0, mism = 0;
   // model: whether a load stall has been granted (WB forward owed next), the
   // operands that forward, current stall run, and exact event counts
   bit m_lw, m_fa, m_fb, m_err;
   int m_run, m_sc, m_fc;

   always #5 clk = ~clk;

   branch_stall_ctrl #(.CNT_W(16), .MAX_STALL(4)) dut (
      .clk(clk), .rst_n(rst_n), .signalA(signalA), .signalB(signalB),
      .ex_load_use(ex_load_use), .branch_taken(branch_taken), .jump(jump),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .fwd_wb_a(fwd_wb_a), .fwd_wb_b(fwd_wb_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hazard_err(hazard_err));

   branch_stall_ctrl #(.CNT_W(2), .MAX_STALL(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .signalA(signalA), .signalB(signalB),
      .ex_load_use(ex_load_use), .branch_taken(branch_taken), .jump(jump),
      .pc_en(pc_en2), .if_id_en(if_id_en2), .if_id_flush(if_id_flush2),
      .id_ex_bubble(id_ex_bubble2), .fwd_wb_a(fwd_wb_a2), .fwd_wb_b(fwd_wb_b2),
      .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .hazard_err(hazard_err2));

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_stall();
      bit ld = (signalA == 3'd5) || (signalB == 3'd5);
      return ld || (!m_lw && ex_load_use);
   endfunction

   task automatic check();
      bit st = m_stall();
      bit fl = !st && (branch_taken || jump);
      chk("pc_en", int'(pc_en), int'(!st));
      chk("if_id_en", int'(if_id_en), int'(!st));
      chk("bubble", int'(id_ex_bubble), int'(st));
      chk("flush", int'(if_id_flush), int'(fl));
      chk("fwd_a", int'(fwd_wb_a), int'(m_lw && m_fa));
      chk("fwd_b", int'(fwd_wb_b), int'(m_lw && m_fb));
      chk("stall_cnt", int'(stall_cnt), m_sc);
      chk("flush_cnt", int'(flush_cnt), m_fc);
      chk("hazard_err", int'(hazard_err), int'(m_err));
      chk("stall_cnt2", int'(stall_cnt2), (m_sc > 3) ? 3 : m_sc);
      chk("flush_cnt2", int'(flush_cnt2), (m_fc > 3) ? 3 : m_fc);
   endtask

   task automatic model_edge();
      bit st = m_stall();
      bit fl = !st && (branch_taken || jump);
      bit la = signalA == 3'd5, lb = signalB == 3'd5;
      bit nlw = (la || lb) && !(!m_lw && ex_load_use);
      m_run = st ? m_run + 1 : 0;
      if (m_run >= 4) m_err = 1;
      if (st && m_sc < 65535) m_sc++;
      if (fl && m_fc < 65535) m_fc++;
      m_lw = nlw;
      m_fa = nlw && la;
      m_fb = nlw && lb;
   endtask

   task automatic model_reset();
      m_lw = 0; m_fa = 0; m_fb = 0; m_err = 0; m_run = 0; m_sc = 0; m_fc = 0;
   endtask

   task automatic step(input logic [2:0] a, input logic [2:0] b, input logic elu,
                       input logic bt, input logic j);
      signalA = a; signalB = b; ex_load_use = elu; branch_taken = bt; jump = j;
      @(negedge clk);
      check();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      signalA = 3'd0; signalB = 3'd0; ex_load_use = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      #2 rst_n = 1'b0;
      #1 model_reset();
      check();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      step(5, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("plan2_stall_cnt", int'(stall_cnt), 1);
      chk("plan2_flush_cnt", int'(flush_cnt), 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 5, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("plan3_stall_cnt", int'(stall_cnt), 3);
      step(0, 0, 1, 1, 0);
      chk("plan4_flush_cnt", int'(flush_cnt), 1);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(5, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("plan5_err", int'(hazard_err), 1);
      do_reset();
      step(5, 5, 0, 0, 0);
      do_reset();
      chk("rst_fwd_a", int'(fwd_wb_a), 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, i[0], !i[0]);
      step(0, 0, 0, 0, 0);
      chk("plan6_flush_cnt2", int'(flush_cnt2), 3);
      chk("plan6_flush_cnt", int'(flush_cnt), 5);
      for (int i = 0; i < 400; i++) begin
         if (i % 40 == 0) do_reset();
         step(3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)),
              ($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 3) == 0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule
